// File: rtl/up_counter_sched_pkg.sv
// up_counter_sched_pkg: shared state encoding and default sizing for the counter scheduler.
package up_counter_sched_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
    localparam int DEF_WIDTH = 4;
    localparam int DEF_N_REQ = 2;
endpackage

// File: rtl/up_counter_sched_if.sv
// up_counter_sched_if: requester-side bus of the shared timer scheduler.
interface up_counter_sched_if
    import up_counter_sched_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int N_REQ = DEF_N_REQ
);
    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] limit;
    logic [N_REQ-1:0]       gnt;
    logic [WIDTH-1:0]       count;
    logic                   busy;
    logic [N_REQ-1:0]       done;
    modport master (output req, limit, input gnt, count, busy, done);
    modport slave  (input req, limit, output gnt, count, busy, done);
endinterface

// File: rtl/up_counter_sched_core.sv
// up_counter_core: up-counter with synchronous clear taking priority over enable.
module up_counter_core #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] count_o
);
    logic [WIDTH-1:0] count_q;
    always_ff @(posedge clk or posedge rst)
        if (rst) count_q <= '0;
        else count_q <= clr_i ? '0 : en_i ? count_q + 1'b1 : count_q;
    assign count_o = count_q;
endmodule

// File: rtl/up_counter_sched.sv
// up_counter_sched: round-robin sharing of one up-counter among N_REQ timer requesters.
module up_counter_sched
    import up_counter_sched_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int N_REQ = DEF_N_REQ
) (
    input logic               clk,
    input logic               rst,
    up_counter_sched_if.slave bus
);
    localparam int IW = $clog2(N_REQ);
    state_e           state_q, state_d;
    logic [IW-1:0]    owner_q, owner_d, rr_q, rr_d, pick, owner_nx;
    logic [WIDTH-1:0] limit_q, limit_d, cnt;
    logic [N_REQ-1:0] gnt_q, gnt_d, done_q, done_d;
    logic             clr, en, abort, match;

    // first requester at or above ptr, wrapping; lowest offset wins
    function automatic logic [IW-1:0] rr_pick(input logic [N_REQ-1:0] r, input logic [IW-1:0] ptr);
        rr_pick = ptr;
        for (int k = N_REQ - 1; k >= 0; k--)
            if (r[(int'(ptr) + k) % N_REQ]) rr_pick = IW'((int'(ptr) + k) % N_REQ);
    endfunction

    assign pick     = rr_pick(bus.req, rr_q);
    assign owner_nx = (owner_q == IW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
    assign abort    = (state_q == RUN) && !bus.req[owner_q];
    assign match    = (state_q == RUN) && (cnt == limit_q);

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            rr_q    <= '0;
            limit_q <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            limit_q <= limit_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
        end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        limit_d = limit_q;
        if (state_q == IDLE) begin
            if (|bus.req) begin
                state_d = RUN;
                owner_d = pick;
                limit_d = bus.limit[int'(pick)*WIDTH +: WIDTH];
            end
        end else if (state_q == RUN) begin
            if (abort) begin
                state_d = IDLE;
                rr_d    = owner_nx;
            end else if (match) begin
                state_d = DONE;
            end
        end else begin
            state_d = IDLE;
            rr_d    = owner_nx;
        end
    end

    always_comb begin
        gnt_d  = (state_d == RUN) ? (N_REQ'(1) << owner_d) : '0;
        done_d = (match && !abort) ? (N_REQ'(1) << owner_q) : '0;
        clr    = ((state_q == IDLE) && |bus.req) || abort || (state_q == DONE);
        en     = (state_q == RUN) && !abort && !match;
    end

    up_counter_core #(.WIDTH(WIDTH)) u_core (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (clr),
        .en_i   (en),
        .count_o(cnt)
    );

    assign bus.gnt   = gnt_q;
    assign bus.done  = done_q;
    assign bus.count = cnt;
    assign bus.busy  = (state_q != IDLE);
endmodule

// File: tb/tb_up_counter_sched.sv
// tb_up_counter_sched: directed scoreboard bench for the shared-counter scheduler.
module tb_up_counter_sched;
    localparam int W = 4;
    localparam int N = 2;
    localparam int VW = 2*N + W + 1;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    up_counter_sched_if #(.WIDTH(W), .N_REQ(N)) bus();
    up_counter_sched #(.WIDTH(W), .N_REQ(N)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [VW-1:0] sb[$];
    int vectors = 0;
    int miscompares = 0;

    task automatic exp(input logic [N-1:0] g, input logic [W-1:0] c, input logic b, input logic [N-1:0] d);
        sb.push_back({g, c, b, d});
    endtask

    task automatic chk(input string tag);
        logic [VW-1:0] o, e;
        o = {bus.gnt, bus.count, bus.busy, bus.done};
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $error("FAIL %s scoreboard empty, got %b", tag, o);
        end else begin
            e = sb.pop_front();
            assert (o === e) else begin
                miscompares++;
                $error("FAIL %s gnt/count/busy/done got %b expected %b", tag, o, e);
            end
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        #1;
        chk(tag);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        exp('0, '0, 1'b0, '0);
        chk(tag);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // one full grant: L+1 RUN cycles, a DONE cycle, then an IDLE cycle
    task automatic trans(input int o, input int l, input bit drop, input string tag);
        logic [N-1:0] oh;
        oh = N'(1) << o;
        for (int c = 0; c <= l; c++) begin
            exp(oh, W'(c), 1'b1, '0);
            step({tag, "_run"});
        end
        exp('0, W'(l), 1'b1, oh);
        step({tag, "_done"});
        if (drop) bus.req = '0;
        exp('0, '0, 1'b0, '0);
        step({tag, "_idle"});
    endtask

    always @(negedge clk) begin
        vectors++;
        assert (!(|bus.gnt && |bus.done) && $onehot0(bus.gnt) && $onehot0(bus.done)) else begin
            miscompares++;
            $error("FAIL invariant gnt=%b done=%b", bus.gnt, bus.done);
        end
    end

    initial begin
        bus.req = '0;
        bus.limit = '0;
        @(posedge clk);
        #1;
        exp('0, '0, 1'b0, '0);
        chk("reset");
        rst = 1'b0;
        exp('0, '0, 1'b0, '0);
        step("idle_noreq");
        // single requester, limit 3
        bus.limit = {4'd0, 4'd3};
        bus.req = 2'b01;
        trans(0, 3, 1'b1, "t1");
        exp('0, '0, 1'b0, '0);
        step("t1_quiet");
        // both requesting from reset: 0, 1, 0
        do_reset("t2_rst");
        bus.limit = {4'd1, 4'd2};
        bus.req = 2'b11;
        trans(0, 2, 1'b0, "t2_a");
        trans(1, 1, 1'b0, "t2_b");
        trans(0, 2, 1'b1, "t2_c");
        // limit extremes
        bus.limit = {4'd0, 4'd0};
        bus.req = 2'b01;
        trans(0, 0, 1'b1, "t3_zero");
        bus.limit = {4'd0, 4'd15};
        bus.req = 2'b01;
        trans(0, 15, 1'b1, "t3_max");
        // abort at count 2, then rr must favour requester 1
        do_reset("t4_rst");
        bus.limit = {4'd1, 4'd7};
        bus.req = 2'b01;
        for (int c = 0; c <= 2; c++) begin
            exp(2'b01, W'(c), 1'b1, '0);
            step("t4_run");
        end
        bus.req = 2'b00;
        exp('0, '0, 1'b0, '0);
        step("t4_abort");
        exp('0, '0, 1'b0, '0);
        step("t4_abort_idle");
        bus.req = 2'b11;
        trans(1, 1, 1'b1, "t4_rr");
        // async reset mid-run
        bus.limit = {4'd2, 4'd9};
        bus.req = 2'b01;
        for (int c = 0; c <= 5; c++) begin
            exp(2'b01, W'(c), 1'b1, '0);
            step("t5_run");
        end
        rst = 1'b1;
        #1;
        exp('0, '0, 1'b0, '0);
        chk("t5_async");
        bus.req = 2'b10;
        @(posedge clk);
        #1;
        exp('0, '0, 1'b0, '0);
        chk("t5_held");
        rst = 1'b0;
        trans(1, 2, 1'b1, "t5_after");
        // limit change after grant is ignored
        bus.limit = {4'd0, 4'd3};
        bus.req = 2'b01;
        exp(2'b01, 4'd0, 1'b1, '0);
        step("t6_run");
        bus.limit = {4'd0, 4'd9};
        for (int c = 1; c <= 3; c++) begin
            exp(2'b01, W'(c), 1'b1, '0);
            step("t6_run");
        end
        exp('0, 4'd3, 1'b1, 2'b01);
        step("t6_done");
        bus.req = '0;
        exp('0, '0, 1'b0, '0);
        step("t6_idle");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
